// File: rtl/knap_if.sv
// Handshake and item-load bundle for the knapsack search engine.
// master drives items, thresholds and start; slave returns status and result.
interface knap_if #(
    parameter int N_ITEMS = 15,
    parameter int W       = 8,
    parameter int ACC_W   = 12,
    parameter int IDX_W   = 4
);
    logic               item_we;
    logic [IDX_W-1:0]   item_addr;
    logic [W-1:0]       item_value;
    logic [W-1:0]       item_weight;
    logic [W-1:0]       item_volume;
    logic [W-1:0]       min_value;
    logic [W-1:0]       max_weight;
    logic [W-1:0]       max_volume;
    logic               mode_best;
    logic               start;
    logic               busy;
    logic               done;
    logic               found;
    logic [N_ITEMS-1:0] sol_mask;
    logic [ACC_W-1:0]   sol_value;

    modport master (
        output item_we, item_addr, item_value, item_weight, item_volume,
        output min_value, max_weight, max_volume, mode_best, start,
        input  busy, done, found, sol_mask, sol_value
    );

    modport slave (
        input  item_we, item_addr, item_value, item_weight, item_volume,
        input  min_value, max_weight, max_volume, mode_best, start,
        output busy, done, found, sol_mask, sol_value
    );
endinterface

// File: rtl/knap_search.sv
// Exhaustive multi-constraint 0/1 knapsack search over all selection masks.
// Ports: clk, rst_n (sync, active low), bus (knap_if.slave: items/thresholds/start in, status/result out).
module knap_search #(
    parameter int N_ITEMS = 15,
    parameter int W       = 8,
    parameter int ACC_W   = 12,
    parameter int IDX_W   = 4
) (
    input logic  clk,
    input logic  rst_n,
    knap_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_ITEMS-1:0] cand_q, cand_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_v_q, acc_v_d;
    logic [ACC_W-1:0]   acc_w_q, acc_w_d;
    logic [ACC_W-1:0]   acc_vol_q, acc_vol_d;
    logic [W-1:0]       min_q, min_d;
    logic [W-1:0]       maxw_q, maxw_d;
    logic [W-1:0]       maxvol_q, maxvol_d;
    logic               mode_q, mode_d;
    logic               found_q, found_d;
    logic [N_ITEMS-1:0] mask_q, mask_d;
    logic [ACC_W-1:0]   sval_q, sval_d;

    logic [W-1:0] val_q [N_ITEMS];
    logic [W-1:0] wgt_q [N_ITEMS];
    logic [W-1:0] vol_q [N_ITEMS];

    logic tbl_we;
    logic valid;
    logic take;
    logic last_idx;

    // Table is only writable while no search is running.
    assign tbl_we = bus.item_we
                 && (state_q == S_IDLE || state_q == S_DONE)
                 && ({1'b0, bus.item_addr} < (IDX_W+1)'(N_ITEMS));

    assign last_idx = (idx_q == IDX_W'(N_ITEMS - 1));

    assign valid = (acc_v_q >= ACC_W'(min_q))
                && (acc_w_q <= ACC_W'(maxw_q))
                && (acc_vol_q <= ACC_W'(maxvol_q));

    // Strict '>' keeps the earlier (lower) mask on ties.
    assign take = valid && (!mode_q || !found_q || acc_v_q > sval_q);

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        idx_d     = idx_q;
        acc_v_d   = acc_v_q;
        acc_w_d   = acc_w_q;
        acc_vol_d = acc_vol_q;
        min_d     = min_q;
        maxw_d    = maxw_q;
        maxvol_d  = maxvol_q;
        mode_d    = mode_q;
        found_d   = found_q;
        mask_d    = mask_q;
        sval_d    = sval_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    min_d     = bus.min_value;
                    maxw_d    = bus.max_weight;
                    maxvol_d  = bus.max_volume;
                    mode_d    = bus.mode_best;
                    found_d   = 1'b0;
                    mask_d    = '0;
                    sval_d    = '0;
                    cand_d    = '0;
                    idx_d     = '0;
                    acc_v_d   = '0;
                    acc_w_d   = '0;
                    acc_vol_d = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cand_q[idx_q]) begin
                    acc_v_d   = acc_v_q + ACC_W'(val_q[idx_q]);
                    acc_w_d   = acc_w_q + ACC_W'(wgt_q[idx_q]);
                    acc_vol_d = acc_vol_q + ACC_W'(vol_q[idx_q]);
                end
                idx_d = idx_q + 1'b1;
                if (last_idx) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (take) begin
                    found_d = 1'b1;
                    mask_d  = cand_q;
                    sval_d  = acc_v_q;
                end
                if ((valid && !mode_q) || (&cand_q)) begin
                    state_d = S_DONE;
                end else begin
                    cand_d    = cand_q + 1'b1;
                    idx_d     = '0;
                    acc_v_d   = '0;
                    acc_w_d   = '0;
                    acc_vol_d = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            idx_q     <= '0;
            acc_v_q   <= '0;
            acc_w_q   <= '0;
            acc_vol_q <= '0;
            min_q     <= '0;
            maxw_q    <= '0;
            maxvol_q  <= '0;
            mode_q    <= 1'b0;
            found_q   <= 1'b0;
            mask_q    <= '0;
            sval_q    <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            idx_q     <= idx_d;
            acc_v_q   <= acc_v_d;
            acc_w_q   <= acc_w_d;
            acc_vol_q <= acc_vol_d;
            min_q     <= min_d;
            maxw_q    <= maxw_d;
            maxvol_q  <= maxvol_d;
            mode_q    <= mode_d;
            found_q   <= found_d;
            mask_q    <= mask_d;
            sval_q    <= sval_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                val_q[i] <= '0;
                wgt_q[i] <= '0;
                vol_q[i] <= '0;
            end
        end else if (tbl_we) begin
            val_q[bus.item_addr] <= bus.item_value;
            wgt_q[bus.item_addr] <= bus.item_weight;
            vol_q[bus.item_addr] <= bus.item_volume;
        end
    end

    assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_CHECK);
    assign bus.done      = (state_q == S_DONE);
    assign bus.found     = found_q;
    assign bus.sol_mask  = mask_q;
    assign bus.sol_value = sval_q;

endmodule

// File: tb/tb_knap_search.sv
// Scoreboard bench for knap_search with a 4-item table.
// Expected results are queued at start and compared on the done pulse.
module tb_knap_search;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 10;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    knap_if #(.N_ITEMS(N), .W(W), .ACC_W(AW), .IDX_W(IW)) bus ();

    knap_search #(.N_ITEMS(N), .W(W), .ACC_W(AW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         found;
        bit [N-1:0] mask;
        int         value;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tv[N];
    int   tw[N];
    int   tvol[N];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_item(input int a, input int v, input int w, input int vo);
        @(negedge clk);
        bus.item_we     = 1'b1;
        bus.item_addr   = IW'(a);
        bus.item_value  = W'(v);
        bus.item_weight = W'(w);
        bus.item_volume = W'(vo);
        @(posedge clk);
        #1 bus.item_we = 1'b0;
        tv[a] = v;
        tw[a] = w;
        tvol[a] = vo;
    endtask

    task automatic load_plan();
        load_item(0, 4, 28, 27);
        load_item(1, 8, 8, 27);
        load_item(2, 20, 18, 4);
        load_item(3, 30, 5, 5);
    endtask

    // Independent brute-force reference over the bench's table copy.
    function automatic exp_t model(input int mn, input int mw, input int mvo, input bit best);
        exp_t r;
        int   k;
        r.found = 0;
        r.mask  = '0;
        r.value = 0;
        k = (1 << N) - 1;
        for (int m = 0; m < (1 << N); m++) begin
            int sv, sw, so;
            bit ok;
            sv = 0; sw = 0; so = 0;
            for (int i = 0; i < N; i++) begin
                if ((m >> i) & 1) begin
                    sv += tv[i]; sw += tw[i]; so += tvol[i];
                end
            end
            ok = (sv >= mn) && (sw <= mw) && (so <= mvo);
            if (ok && (!r.found || sv > r.value)) begin
                r.found = 1;
                r.mask  = N'(m);
                r.value = sv;
            end
            if (ok && !best) begin
                k = m;
                break;
            end
        end
        r.lat = (k + 1) * (N + 1) + 1;
        return r;
    endfunction

    task automatic start_search(input int mn, input int mw, input int mvo, input bit best);
        @(negedge clk);
        bus.min_value  = W'(mn);
        bus.max_weight = W'(mw);
        bus.max_volume = W'(mvo);
        bus.mode_best  = best;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Waits for done, optionally poking item_we/start/thresholds at cycle 'poke'.
    task automatic finish_search(input string tag, input int poke);
        int   cyc;
        int   extra;
        bit   ok;
        exp_t e;
        cyc = 0;
        ok  = 0;
        while (cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                bus.item_we     = 1'b1;
                bus.item_addr   = '0;
                bus.item_value  = 8'd99;
                bus.item_weight = 8'd0;
                bus.item_volume = 8'd0;
                bus.start       = 1'b1;
                bus.min_value   = 8'd0;
                bus.mode_best   = 1'b1;
            end else if (cyc == poke + 1) begin
                bus.item_we = 1'b0;
                bus.start   = 1'b0;
            end
            if (bus.done) begin
                ok = 1;
                break;
            end
        end
        e = sb.pop_front();
        chk({tag, "_timeout"}, int'(ok), 1);
        if (ok) begin
            chk({tag, "_lat"}, cyc, e.lat);
            chk({tag, "_found"}, int'(bus.found), int'(e.found));
            chk({tag, "_mask"}, int'(bus.sol_mask), int'(e.mask));
            chk({tag, "_value"}, int'(bus.sol_value), e.value);
            chk({tag, "_busy_in_done"}, int'(bus.busy), 0);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk({tag, "_extra_done"}, extra, 0);
        chk({tag, "_hold_mask"}, int'(bus.sol_mask), int'(e.mask));
    endtask

    task automatic push(input bit f, input int m, input int v, input int l);
        exp_t e;
        e.found = f;
        e.mask  = N'(m);
        e.value = v;
        e.lat   = l;
        sb.push_back(e);
    endtask

    initial begin
        int cnt;
        bus.item_we     = 1'b0;
        bus.item_addr   = '0;
        bus.item_value  = '0;
        bus.item_weight = '0;
        bus.item_volume = '0;
        bus.min_value   = '0;
        bus.max_weight  = '0;
        bus.max_volume  = '0;
        bus.mode_best   = 1'b0;
        bus.start       = 1'b0;
        for (int i = 0; i < N; i++) begin
            tv[i] = 0; tw[i] = 0; tvol[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_found", int'(bus.found), 0);
        chk("rst_mask", int'(bus.sol_mask), 0);
        chk("rst_value", int'(bus.sol_value), 0);

        load_plan();

        push(1, 4'b1100, 50, 66);
        start_search(50, 60, 60, 0);
        finish_search("first", 0);

        push(1, 4'b1110, 58, 81);
        start_search(50, 60, 60, 1);
        finish_search("best", 0);

        push(0, 0, 0, 81);
        start_search(100, 60, 60, 1);
        finish_search("none", 0);

        push(1, 0, 0, 6);
        start_search(0, 60, 60, 0);
        finish_search("zero", 0);

        push(1, 4'b1100, 50, 66);
        start_search(50, 60, 60, 0);
        finish_search("poke", 20);

        push(1, 4'b1100, 50, 66);
        start_search(50, 60, 60, 0);
        finish_search("after_poke", 0);

        start_search(0, 60, 60, 1);
        repeat (10) @(negedge clk);
        chk("pre_rst_found", int'(bus.found), 1);
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_found", int'(bus.found), 0);
        chk("mid_rst_mask", int'(bus.sol_mask), 0);
        chk("mid_rst_value", int'(bus.sol_value), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("mid_rst_no_done", cnt, 0);
        for (int i = 0; i < N; i++) begin
            tv[i] = 0; tw[i] = 0; tvol[i] = 0;
        end

        push(0, 0, 0, 81);
        start_search(1, 60, 60, 0);
        finish_search("cleared", 0);

        load_plan();
        push(1, 4'b1100, 50, 66);
        start_search(50, 60, 60, 0);
        finish_search("reload_first", 0);
        push(1, 4'b1110, 58, 81);
        start_search(50, 60, 60, 1);
        finish_search("reload_best", 0);

        for (int t = 0; t < 4; t++) begin
            int mn, mw, mvo;
            bit best;
            exp_t e;
            for (int i = 0; i < N; i++) begin
                load_item(i, $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255));
            end
            mn   = $urandom_range(0, 255);
            mw   = $urandom_range(0, 255);
            mvo  = $urandom_range(0, 255);
            best = 1'($urandom_range(0, 1));
            e = model(mn, mw, mvo, best);
            sb.push_back(e);
            start_search(mn, mw, mvo, best);
            finish_search($sformatf("rand%0d", t), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
